// File: rtl/hrx_pkg.sv
// Shared types, widths and error-flag indices for the Hamming receive sequencer.
package hrx_pkg;

    localparam int CODE_W  = 7;
    localparam int NIB_W   = 4;
    localparam int SYN_W   = 3;
    localparam int BYTE_W  = 2 * NIB_W;
    localparam int ENTRY_W = BYTE_W + 1;
    localparam int ERR_W   = 4;
    localparam int CNT_W   = 16;

    localparam int ERR_DEC_TO = 0;
    localparam int ERR_GAP    = 1;
    localparam int ERR_OVF    = 2;
    localparam int ERR_OVR    = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DECODE   = 2'd1,
        ASSEMBLE = 2'd2
    } hrx_state_e;

    // A nonzero syndrome means the decoder repaired one bit of the codeword.
    function automatic logic syn_corrected(input logic [SYN_W-1:0] syn);
        return |syn;
    endfunction

endpackage : hrx_pkg

// File: rtl/hrx_byte_fifo.sv
// Small synchronous FIFO holding assembled bytes plus their correction bit.
// Push while full is accepted only when a pop happens in the same cycle.
module hrx_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == {(AW + 1){1'b0}});
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign dout      = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule : hrx_byte_fifo

// File: rtl/hamming_rx_sequencer.sv
// Sequences UART codewords through an external Hamming(7,4) decoder and packs nibble pairs into bytes.
// Optional corrected-nibble counter enabled by defining HRX_STATS_EN.
module hamming_rx_sequencer
    import hrx_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int DEC_TIMEOUT = 15,
    parameter int GAP_TIMEOUT = 4095
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [CODE_W-1:0] rx_code,
    output logic              dec_en,
    output logic [CODE_W-1:0] dec_code,
    input  logic              dec_valid,
    input  logic [NIB_W-1:0]  dec_data,
    input  logic [SYN_W-1:0]  dec_syndrome,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_corr,
    output logic              busy,
    output logic [ERR_W-1:0]  err_flags,
    input  logic              clr_err,
    output logic [CNT_W-1:0]  corr_cnt
);

    localparam int DW = $clog2(DEC_TIMEOUT + 1);
    localparam int GW = $clog2(GAP_TIMEOUT + 1);
    localparam logic [DW-1:0] DEC_LAST = DW'(DEC_TIMEOUT - 1);
    localparam logic [DW-1:0] DEC_INC  = DW'(1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_INC  = GW'(1);

    hrx_state_e          state_r;
    logic                dec_en_r;
    logic [CODE_W-1:0]   dec_code_r;
    logic [DW-1:0]       wait_cnt_r;
    logic [GW-1:0]       gap_cnt_r;
    logic                half_r;
    logic [NIB_W-1:0]    nib_r;
    logic                corr_r;
    logic [NIB_W-1:0]    low_r;
    logic                corr_low_r;
    logic [ERR_W-1:0]    err_r;

    logic                dec_to_s;
    logic                gap_to_s;
    logic                push_s;
    logic                pop_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [ENTRY_W-1:0]  fifo_din_s;
    logic [ENTRY_W-1:0]  fifo_dout_s;
    logic [ERR_W-1:0]    err_set_s;

    assign dec_to_s   = (state_r == DECODE) && !dec_valid && (wait_cnt_r == DEC_LAST);
    assign gap_to_s   = (state_r == IDLE) && half_r && (gap_cnt_r == GAP_LAST);
    assign push_s     = (state_r == ASSEMBLE) && half_r;
    assign pop_s      = out_ready && !fifo_empty_s;
    assign fifo_din_s = {nib_r, low_r, corr_r | corr_low_r};

    assign dec_en    = dec_en_r;
    assign dec_code  = dec_code_r;
    assign out_valid = ~fifo_empty_s;
    assign out_data  = fifo_dout_s[ENTRY_W-1:1];
    assign out_corr  = fifo_dout_s[0];
    assign busy      = (state_r != IDLE) || half_r;
    assign err_flags = err_r;

    hrx_byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (fifo_din_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Receive FSM with decode wait timer, gap timer and nibble pairing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            dec_en_r   <= 1'b0;
            dec_code_r <= {CODE_W{1'b0}};
            wait_cnt_r <= {DW{1'b0}};
            gap_cnt_r  <= {GW{1'b0}};
            half_r     <= 1'b0;
            nib_r      <= {NIB_W{1'b0}};
            corr_r     <= 1'b0;
            low_r      <= {NIB_W{1'b0}};
            corr_low_r <= 1'b0;
        end else begin
            dec_en_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (gap_to_s) begin
                        half_r    <= 1'b0;
                        gap_cnt_r <= {GW{1'b0}};
                    end else if (half_r) begin
                        gap_cnt_r <= gap_cnt_r + GAP_INC;
                    end
                    if (rx_valid) begin
                        dec_code_r <= rx_code;
                        dec_en_r   <= 1'b1;
                        wait_cnt_r <= {DW{1'b0}};
                        state_r    <= DECODE;
                    end
                end
                DECODE: begin
                    if (dec_valid) begin
                        nib_r   <= dec_data;
                        corr_r  <= syn_corrected(dec_syndrome);
                        state_r <= ASSEMBLE;
                    end else if (dec_to_s) begin
                        state_r <= IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + DEC_INC;
                    end
                end
                ASSEMBLE: begin
                    if (half_r) begin
                        half_r <= 1'b0;
                    end else begin
                        low_r      <= nib_r;
                        corr_low_r <= corr_r;
                        half_r     <= 1'b1;
                        gap_cnt_r  <= {GW{1'b0}};
                    end
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Collect this cycle's error events.
    always_comb begin
        err_set_s             = {ERR_W{1'b0}};
        err_set_s[ERR_DEC_TO] = dec_to_s;
        err_set_s[ERR_GAP]    = gap_to_s;
        err_set_s[ERR_OVF]    = push_s && fifo_full_s && !pop_s;
        err_set_s[ERR_OVR]    = rx_valid && (state_r != IDLE);
    end

    // Sticky flags; a new event in the clearing cycle survives the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= {ERR_W{1'b0}};
        end else if (clr_err) begin
            err_r <= err_set_s;
        end else begin
            err_r <= err_r | err_set_s;
        end
    end

`ifdef HRX_STATS_EN
    logic [CNT_W-1:0] corr_cnt_r;
    logic             cnt_inc_s;

    assign cnt_inc_s = (state_r == ASSEMBLE) && corr_r;
    assign corr_cnt  = corr_cnt_r;

    // Saturating count of corrected nibbles, zeroed by clr_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            corr_cnt_r <= {CNT_W{1'b0}};
        end else if (clr_err) begin
            corr_cnt_r <= {{(CNT_W - 1){1'b0}}, cnt_inc_s};
        end else if (cnt_inc_s && (corr_cnt_r != {CNT_W{1'b1}})) begin
            corr_cnt_r <= corr_cnt_r + {{(CNT_W - 1){1'b0}}, 1'b1};
        end else begin
            corr_cnt_r <= corr_cnt_r;
        end
    end
`else
    assign corr_cnt = {CNT_W{1'b0}};
`endif

endmodule : hamming_rx_sequencer
